// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: round-robin front end that shares one registered
// logic-gate unit among N_REQ requesters and returns tagged responses.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; combinational req_ready to the winner, latch on accept
// EXEC  | evaluate the latched op, register result/id/err
// RESP  | hold response until resp_ready, then back to IDLE
module gate_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              grant_found;
  logic              accept;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  gate_result;
  logic              gate_err;

  // Round-robin scan: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign accept = (state == S_IDLE) && grant_found;

  // One-hot ready to the winner only, forced low while in reset.
  always_comb begin
    req_ready = '0;
    if (accept && !rst) req_ready[grant_idx] = 1'b1;
  end

  // Next-state logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_found) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Gate evaluation on the latched operands; opcode 7 is flagged illegal.
  always_comb begin
    gate_result = '0;
    gate_err    = 1'b0;
    case (op_q)
      3'd0:    gate_result = a_q & b_q;
      3'd1:    gate_result = a_q | b_q;
      3'd2:    gate_result = ~a_q;
      3'd3:    gate_result = ~(a_q & b_q);
      3'd4:    gate_result = ~(a_q | b_q);
      3'd5:    gate_result = a_q ^ b_q;
      3'd6:    gate_result = ~(a_q ^ b_q);
      default: gate_err    = 1'b1;
    endcase
  end

  // State, pointer, request latch and response registers; rst wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      resp_data <= '0;
      resp_id   <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req_op[3*grant_idx +: 3];
        a_q  <= req_a[WIDTH*grant_idx +: WIDTH];
        b_q  <= req_b[WIDTH*grant_idx +: WIDTH];
        id_q <= grant_idx;
        if (grant_idx == ID_W'(N_REQ-1)) ptr <= '0;
        else                             ptr <= grant_idx + ID_W'(1);
      end
      if (state == S_EXEC) begin
        resp_data <= gate_result;
        resp_id   <= id_q;
        resp_err  <= gate_err;
      end
    end
  end

  assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: directed stimulus pushes expected responses
// into a queue; a monitor pops and compares on each response handshake.
module tb_gate_unit_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [3*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WIDTH-1:0]       resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_err;

  gate_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   spacing_on = 1'b0;
  bit   have_prev  = 1'b0;
  int   prev_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] id, input logic err);
    exp_t e;
    e.data = d; e.id = id; e.err = err;
    q.push_back(e);
  endtask

  task automatic set_payload(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  // Raise valid for requester i, wait (bounded) for its one-hot grant,
  // step over the accept edge and withdraw valid.
  task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    logic [3:0] onehot;
    set_payload(i, op, a, b);
    req_valid[i] = 1'b1;
    onehot = 4'b0001 << i;
    n = 0;
    #1;
    while (!req_ready[i] && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("grant_onehot", {28'd0, req_ready}, {28'd0, onehot});
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  // Monitor: compare each completed response against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          check("unexpected_resp", {22'd0, resp_err, resp_id, resp_data}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_id",   resp_id,   e.id);
          check("resp_err",  resp_err,  e.err);
          if (spacing_on) begin
            if (have_prev) check("resp_spacing", cyc - prev_cyc, 3);
            have_prev = 1'b1;
            prev_cyc  = cyc;
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    // Reset: outputs cleared, no ready even with all requesters valid.
    tick(); tick();
    req_valid = 4'b1111;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_err", resp_err, 0);
    tick();
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Single request from requester 2: AND 0xF0,0x3C -> 0x30.
    resp_ready = 1'b1;
    push(8'h30, 2'd2, 1'b0);
    issue(2, 3'd0, 8'hF0, 8'h3C);
    check("exec_no_valid", resp_valid, 0);
    tick();
    check("resp_after_accept", resp_valid, 1);
    tick();
    check("idle_after_hs", resp_valid, 0);

    // All opcodes from requester 0 with a=0xA5, b=0x0F.
    push(8'h05, 2'd0, 1'b0); issue(0, 3'd0, 8'hA5, 8'h0F); tick(); tick();
    push(8'hAF, 2'd0, 1'b0); issue(0, 3'd1, 8'hA5, 8'h0F); tick(); tick();
    push(8'h5A, 2'd0, 1'b0); issue(0, 3'd2, 8'hA5, 8'h0F); tick(); tick();
    push(8'hFA, 2'd0, 1'b0); issue(0, 3'd3, 8'hA5, 8'h0F); tick(); tick();
    push(8'h50, 2'd0, 1'b0); issue(0, 3'd4, 8'hA5, 8'h0F); tick(); tick();
    push(8'hAA, 2'd0, 1'b0); issue(0, 3'd5, 8'hA5, 8'h0F); tick(); tick();
    push(8'h55, 2'd0, 1'b0); issue(0, 3'd6, 8'hA5, 8'h0F); tick(); tick();
    push(8'h00, 2'd0, 1'b1); issue(0, 3'd7, 8'hA5, 8'h0F); tick(); tick();
    drain(10);

    // Reset so ptr=0, then all four requesters valid continuously.
    rst = 1'b1; tick(); rst = 1'b0;
    set_payload(0, 3'd0, 8'hCC, 8'hAA);
    set_payload(1, 3'd5, 8'hCC, 8'hAA);
    set_payload(2, 3'd1, 8'hCC, 8'hAA);
    set_payload(3, 3'd4, 8'hCC, 8'hAA);
    for (int r = 0; r < 2; r++) begin
      push(8'h88, 2'd0, 1'b0);
      push(8'h66, 2'd1, 1'b0);
      push(8'hEE, 2'd2, 1'b0);
      push(8'h11, 2'd3, 1'b0);
    end
    spacing_on = 1'b1;
    have_prev  = 1'b0;
    req_valid  = 4'b1111;
    drain(40);
    req_valid  = '0;
    spacing_on = 1'b0;
    tick();

    // ptr=0 now; serve requester 1 so ptr=2, then 1 and 3 both valid.
    push(8'h81, 2'd1, 1'b0);
    issue(1, 3'd0, 8'hFF, 8'h81); tick(); tick();
    drain(5);
    set_payload(1, 3'd2, 8'h3C, 8'h00);
    set_payload(3, 3'd6, 8'hF0, 8'h0F);
    push(8'h00, 2'd3, 1'b0);
    push(8'hC3, 2'd1, 1'b0);
    push(8'h00, 2'd3, 1'b0);
    req_valid = 4'b1010;
    drain(20);
    req_valid = '0;
    tick();

    // Backpressure: hold RESP for 5 cycles with other requesters pending.
    resp_ready = 1'b0;
    push(8'hF0, 2'd2, 1'b0);
    issue(2, 3'd3, 8'h0F, 8'hFF);
    req_valid = 4'b1011;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", resp_valid, 1);
      check("bp_data", resp_data, 8'hF0);
      check("bp_id", resp_id, 2);
      check("bp_ready", req_ready, 0);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    check("bp_release_idle", resp_valid, 0);
    check("bp_drained", q.size(), 0);

    // Reset during EXEC: no response, ptr back to 0.
    resp_ready = 1'b0;
    issue(0, 3'd0, 8'hFF, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_exec_valid", resp_valid, 0);
    req_valid = 4'b0011;
    #1;
    check("rst_exec_ptr", req_ready, 4'b0001);
    req_valid = '0;
    tick();

    // Reset during RESP: response dropped, ptr back to 0.
    issue(1, 3'd1, 8'h12, 8'h34);
    tick();
    check("pre_rst_resp", resp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_resp_valid", resp_valid, 0);
    req_valid = 4'b0110;
    #1;
    check("rst_resp_ptr", req_ready, 4'b0010);
    req_valid = '0;
    resp_ready = 1'b1;
    tick(); tick(); tick();
    check("no_stale_resp", resp_valid, 0);

    // Fresh request completes normally after the resets.
    push(8'h3C, 2'd3, 1'b0);
    issue(3, 3'd5, 8'h5A, 8'h66);
    drain(10);
    tick(); tick();
    check("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_unit_arbiter.md
# gate_unit_arbiter

Shares one registered multi-bit logic-gate unit (AND, OR, NOT, NAND, NOR, XOR, XNOR) among several requesters. Each requester issues an opcode and two operands over a valid/ready handshake. A round-robin arbiter grants one request at a time. The result goes back on a single response channel tagged with the requester ID. The block sits between the per-lane control logic and the gate datapath, so one gate unit serves all lanes instead of one per lane.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- ID_W, $clog2(N_REQ), width of resp_id

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  per-requester accept; at most one bit high
- req_op  input  3*N_REQ  opcode, requester i at bits [3i+2:3i]
- req_a  input  WIDTH*N_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
- req_b  input  WIDTH*N_REQ  operand B, same packing
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumer ready
- resp_data  output  WIDTH  result
- resp_id  output  ID_W  index of the requester served
- resp_err  output  1  illegal opcode flag

## Operation
- Opcodes:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 NOT: ~a, b ignored
  - 3 NAND: ~(a&b)
  - 4 NOR: ~(a|b)
  - 5 XOR: a^b
  - 6 XNOR: ~(a^b)
  - 7 illegal: resp_data=0, resp_err=1
  - resp_err=0 for all legal opcodes.
- FSM states:
  - IDLE:
    - The arbiter picks the first i with req_valid[i]=1, scanning from ptr upward and wrapping modulo N_REQ.
    - req_ready[i] is driven combinationally for that i only.
    - On accept, the block latches op, a, b and id into internal registers, sets ptr=(i+1)%N_REQ, and moves to EXEC.
    - With no valid request it stays in IDLE and ptr is unchanged.
  - EXEC: computes the latched operation, registers resp_data/resp_id/resp_err, then moves to RESP.
  - RESP:
    - resp_valid=1, and resp_data/resp_id/resp_err are held stable.
    - When resp_valid&resp_ready, the block moves to IDLE.
- req_ready is 0 in EXEC and RESP; no new request is accepted until the response completes.
- Requesters hold req_valid and payload stable until accepted. Deasserting valid before accept withdraws the request and is legal.
- Reset values:
  - state=IDLE, ptr=0
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0
  - req_ready is combinational; it is 0 while rst=1.
- Reset mid-operation (EXEC or RESP) drops the transaction with no response. rst overrides every other event in the same cycle.
- Starvation-free: a requester that keeps valid asserted is granted within N_REQ grants.

## Timing
- Accept sampled at edge k (IDLE, req_valid[i]&req_ready[i]).
- State is EXEC after edge k and RESP after edge k+1. resp_valid is high from edge k+1 until the edge where resp_ready=1 is sampled.
- Minimum period per transaction with resp_ready held high: 3 cycles (accept, EXEC, RESP). The next accept can occur at the edge after the response handshake.
- resp_ready is don't-care outside RESP.
- The arbiter decision depends only on the current req_valid and ptr. req_ready has no registered delay.

## Test plan
- After rst, single request: req 2 valid, op=0, a=0xF0, b=0x3C -> req_ready[2] high in the same cycle; resp_valid one edge after accept with resp_data=0x30, resp_id=2, resp_err=0.
- All 8 opcodes from req 0 with a=0xA5, b=0x0F, resp_ready high -> resp_data 0x05, 0xAF, 0x5A, 0xFA, 0x50, 0xAA, 0x55, then 0x00 with resp_err=1.
- All 4 requesters valid continuously, resp_ready high -> grant order 0,1,2,3,0,1…, one response every 3 cycles, resp_id matching that order.
- Backpressure: resp_ready low for 5 cycles in RESP -> resp_valid, resp_data and resp_id stay constant; all req_ready stay 0; after resp_ready rises, IDLE follows on the next edge.
- Only req 1 and req 3 valid, ptr=2 -> req 3 granted first, then req 1, then req 3.
- rst asserted during EXEC and during RESP -> resp_valid=0 and ptr=0 on the next edge; no stale response appears; a fresh request afterwards completes normally.
